// File: rtl/div_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// div_sequencer_pkg : shared RV32M divide codes, FSM states and op decoding
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package div_sequencer_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // funct7 shared by every M-extension instruction, decoded by the control unit
  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic op_is_signed(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // Unlisted codes fall through as DIVU
  function automatic logic op_is_rem(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step : one combinational radix-2 restoring division iteration
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  // rem < divisor keeps the true trial inside the WIDTH+1 bit signed range
  assign w_shifted = {rem, quo[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, divisor};
  assign rem_next  = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign quo_next  = {quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

`default_nettype wire

// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer : multi-cycle RV32M DIV/DIVU/REM/REMU sequencer for EX stage
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_cnt;
  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_result;

  logic             w_signed;
  logic             w_rem_op;
  logic             w_accept;
  logic             w_div_zero;
  logic             w_overflow;
  logic             w_fast;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH-1:0] w_fast_result;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_signed   = op_is_signed(funct3);
  assign w_rem_op   = op_is_rem(funct3);
  assign w_mag1     = (w_signed && data1[WIDTH-1]) ? -data1 : data1;
  assign w_mag2     = (w_signed && data2[WIDTH-1]) ? -data2 : data2;
  assign w_div_zero = (data2 == '0);
  assign w_overflow = w_signed && (data1 == MIN_NEG) && (data2 == '1);
  assign w_fast     = w_div_zero || w_overflow;
  assign w_accept   = (r_state == S_IDLE) && start && !flush;

  // Overflow quotient equals the dividend itself (most negative value)
  assign w_fast_result = w_div_zero ? (w_rem_op ? data1 : '1)
                                    : (w_rem_op ? '0    : data1);

  assign w_q_fix = r_neg_q ? -r_quo : r_quo;
  assign w_r_fix = r_neg_r ? -r_rem : r_rem;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (r_rem),
    .quo      (r_quo),
    .divisor  (r_divisor),
    .rem_next (w_rem_next),
    .quo_next (w_quo_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_state_next = w_fast ? S_DONE : S_CALC;
        S_CALC:  if (r_cnt == '0) w_state_next = S_FIX;
        S_FIX:   w_state_next = S_DONE;
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_is_rem  <= w_rem_op;
            r_neg_q   <= w_signed && (data1[WIDTH-1] ^ data2[WIDTH-1]);
            r_neg_r   <= w_signed && data1[WIDTH-1];
            r_quo     <= w_mag1;
            r_divisor <= w_mag2;
            if (w_fast) begin
              r_result <= w_fast_result;
            end else begin
              r_rem <= '0;
              r_cnt <= CNT_LOAD;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          r_result <= r_is_rem ? w_r_fix : w_q_fix;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
  assign done   = (r_state == S_DONE);
  assign stall  = busy || w_accept;

endmodule

`default_nettype wire
